// File: rtl/alu_pkg.sv
// Shared definitions for the operand-fetch stage and the ALU stage behind it:
// widths, op encodings and the operand bundle passed between them.
package alu_pkg;

  localparam int W     = 16;
  localparam int NREGS = 8;
  localparam int RW    = $clog2(NREGS);

  localparam logic [1:0] OP_NOT    = 2'd0;
  localparam logic [1:0] OP_AND    = 2'd1;
  localparam logic [1:0] OP_ADD    = 2'd2;
  localparam logic [1:0] OP_SATADD = 2'd3;

  typedef struct packed {
    logic [1:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [RW-1:0] rd;
  } opnd_bundle_t;

endpackage

// File: rtl/opnd_scoreboard.sv
// Tracks destinations still awaiting writeback and flags issue hazards
// on any of the source or destination registers.
module opnd_scoreboard
  import alu_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          set_en,
  input  logic [RW-1:0] set_idx,
  input  logic          clr_en,
  input  logic [RW-1:0] clr_idx,
  input  logic [RW-1:0] ra,
  input  logic [RW-1:0] rb,
  input  logic [RW-1:0] rd,
  output logic          hazard
);

  logic [NREGS-1:0] pending_r;
  logic [NREGS-1:0] pending_nxt_s;

  // A register is blocking unless its writeback lands in this very cycle.
  function automatic logic blocked(input logic [NREGS-1:0] pend,
                                   input logic [RW-1:0]    idx,
                                   input logic             c_en,
                                   input logic [RW-1:0]    c_idx);
    blocked = pend[idx] && !(c_en && (c_idx == idx));
  endfunction

  // Next pending vector; the set is applied after the clear so it wins.
  always_comb begin
    pending_nxt_s = pending_r;
    if (clr_en) begin
      pending_nxt_s[clr_idx] = 1'b0;
    end else begin
      pending_nxt_s = pending_nxt_s;
    end
    if (set_en && (set_idx != 3'd0)) begin
      pending_nxt_s[set_idx] = 1'b1;
    end else begin
      pending_nxt_s = pending_nxt_s;
    end
    pending_nxt_s[0] = 1'b0;
  end

  // Pending-bit register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_r <= '0;
    end else begin
      pending_r <= pending_nxt_s;
    end
  end

  // Hazard on any operand or destination that is still outstanding.
  always_comb begin
    hazard = blocked(pending_r, ra, clr_en, clr_idx) ||
             blocked(pending_r, rb, clr_en, clr_idx) ||
             blocked(pending_r, rd, clr_en, clr_idx);
  end

endmodule

// File: rtl/alu_opnd_stage.sv
// Operand-fetch stage: register file with writeback bypass, hazard stall via
// the scoreboard, and a registered valid/ready operand bundle for the ALU.
module alu_opnd_stage
  import alu_pkg::*;
#(
  parameter int W     = alu_pkg::W,
  parameter int NREGS = alu_pkg::NREGS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    in_op,
  input  logic [RW-1:0] in_ra,
  input  logic [RW-1:0] in_rb,
  input  logic [RW-1:0] in_rd,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [1:0]    out_op,
  output logic [W-1:0]  out_a,
  output logic [W-1:0]  out_b,
  output logic [RW-1:0] out_rd,
  input  logic          wb_en,
  input  logic [RW-1:0] wb_rd,
  input  logic [W-1:0]  wb_data
);

  logic [W-1:0] regs_r [NREGS];
  opnd_bundle_t bundle_r;
  logic         valid_r;
  logic         hazard_s;
  logic         accept_s;
  logic [W-1:0] opnd_a_s;
  logic [W-1:0] opnd_b_s;

  opnd_scoreboard u_sb (
    .clk     (clk),
    .rst     (rst),
    .set_en  (accept_s),
    .set_idx (in_rd),
    .clr_en  (wb_en),
    .clr_idx (wb_rd),
    .ra      (in_ra),
    .rb      (in_rb),
    .rd      (in_rd),
    .hazard  (hazard_s)
  );

  // Issue handshake; in_valid only qualifies the accept, never in_ready.
  always_comb begin
    in_ready = !hazard_s && (!valid_r || out_ready);
    accept_s = in_valid && in_ready;
  end

  // Operand reads: r0 is hard zero, same-cycle writeback is forwarded.
  always_comb begin
    opnd_a_s = '0;
    opnd_b_s = '0;
    if (in_ra == 3'd0) begin
      opnd_a_s = '0;
    end else if (wb_en && (wb_rd == in_ra)) begin
      opnd_a_s = wb_data;
    end else begin
      opnd_a_s = regs_r[in_ra];
    end
    if (in_rb == 3'd0) begin
      opnd_b_s = '0;
    end else if (wb_en && (wb_rd == in_rb)) begin
      opnd_b_s = wb_data;
    end else begin
      opnd_b_s = regs_r[in_rb];
    end
  end

  // Register file write port; r0 writes are discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= '0;
      end
    end else if (wb_en && (wb_rd != 3'd0)) begin
      regs_r[wb_rd] <= wb_data;
    end
  end

  // Output bundle: load on accept, drop valid on drain, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r  <= 1'b0;
      bundle_r <= '0;
    end else if (accept_s) begin
      valid_r     <= 1'b1;
      bundle_r.op <= in_op;
      bundle_r.a  <= opnd_a_s;
      bundle_r.b  <= opnd_b_s;
      bundle_r.rd <= in_rd;
    end else if (out_ready) begin
      valid_r <= 1'b0;
    end
  end

  always_comb begin
    out_valid = valid_r;
    out_op    = bundle_r.op;
    out_a     = bundle_r.a;
    out_b     = bundle_r.b;
    out_rd    = bundle_r.rd;
  end

endmodule

// File: doc/alu_opnd_stage.md
# alu_opnd_stage

Operand-fetch stage directly upstream of the 16-bit ALU (NOT/AND/ADD/dual-lane saturating ADD, selected by a 2-bit op). It holds an 8-entry × 16-bit register file, tracks in-flight destinations with a scoreboard, and stalls issue on hazards. It writes ALU results back and bypasses same-cycle writeback data into operands. It presents a registered, valid/ready-handshaked operand bundle to the ALU stage.

## Interface
Parameters:
- W, 16, datapath width
- NREGS, 8, register count (index width log2(NREGS) = 3)

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock, synchronous, active-high
- in_valid  in  1  instruction offered
- in_ready  out  1  instruction accepted this cycle when in_valid && in_ready
- in_op  in  2  ALU op select: 0 NOT, 1 AND, 2 ADD, 3 SATADD
- in_ra, in_rb, in_rd  in  3 each  source A, source B, destination
- out_valid  out  1  operand bundle valid
- out_ready  in  1  ALU stage accepts bundle
- out_op  out  2  registered op
- out_a, out_b  out  W each  registered operands
- out_rd  out  3  registered destination
- wb_en  in  1  writeback strobe from ALU
- wb_rd  in  3  writeback destination
- wb_data  in  W  writeback value

## Operation
- Register file:
  - r0 always reads 0; writes to r0 are dropped.
  - r1..r7 are written on wb_en.
- Scoreboard: pending[7:0], with pending[0] tied to 0.
  - Issue sets pending[in_rd] if in_rd≠0.
  - wb_en clears pending[wb_rd].
  - Set and clear of the same index in the same cycle: set wins.
  - wb_en to a non-pending register still writes the file; no error.
- Hazard exists if pending[x] is set for any x ∈ {ra, rb, rd}, unless wb_en && wb_rd==x this cycle.
  - Covering rd prevents WAW reordering.
- in_ready = !hazard && (!out_valid || out_ready).
- On accept:
  - out_a ← bypassed read of ra, where the bypass is wb_data if wb_en && wb_rd==ra && ra≠0.
  - out_b ← bypassed read of rb, same rule.
  - out_op, out_rd are registered; out_valid ← 1.
- Output held: while out_valid && !out_ready, all out_* stay stable and no new accept occurs.
- Drain: out_valid && out_ready && no accept ⇒ out_valid ← 0. out_* data keeps its last value.

## Timing
- Reset values:
  - out_valid=0; out_op=0, out_a=0, out_b=0, out_rd=0.
  - All registers 0; pending all 0.
  - in_ready=1 in the cycle after reset, provided out_valid=0 and there are no hazards.
- Latency: accept in cycle N ⇒ out_valid=1 with operands in cycle N+1.
- Throughput: one instruction per cycle with independent registers and out_ready=1.
- RAW via writeback:
  - Dependent instruction stalls until the wb_en cycle for its source.
  - It is accepted in that same cycle with the bypassed value.
  - No extra bubble.
- Write-then-read of the file: a write at edge N is visible to reads in cycle N+1 and later.
- Reset mid-operation:
  - Rule: reset overrides wb_en and accept.
  - Effect: pending is cleared, the in-flight bundle is discarded, and the file is zeroed.
- in_ready is combinational from in_ra/in_rb/in_rd, wb_en/wb_rd, out_ready, and state. There is no combinational path from in_valid to in_ready.

## Structure
- Shared package alu_pkg holds:
  - W and NREGS
  - op-encoding constants OP_NOT=2'd0, OP_AND=2'd1, OP_ADD=2'd2, OP_SATADD=2'd3, also used by the ALU stage
  - typedef of the operand bundle {op, a, b, rd}
- Natural sub-module: opnd_scoreboard.
  - Contents: pending bits, set/clear priority, and the hazard output.
  - Everything else lives in alu_opnd_stage.

## Test plan
- Reset, then write r3=0x00FF via wb, issue ADD ra=3 rb=0 rd=4 → next cycle out_valid=1, out_op=2, out_a=0x00FF, out_b=0x0000, out_rd=4.
- Issue rd=5, then next instruction ra=5: verify two things.
  - in_ready=0 until wb_en wb_rd=5 wb_data=0x7F80.
  - In that cycle it accepts, and the following cycle gives out_a=0x7F80.
- Hold out_ready=0 for 3 cycles with out_valid=1 → out_* stable, in_ready=0. Raise out_ready → one bundle drains, the next is accepted in the same cycle.
- Simultaneous events:
  - Stimulus: issue with rd=2 in the same cycle as wb_en wb_rd=2.
  - Required response: pending[2]=1 afterwards, so a following read of r2 stalls.
- wb_en wb_rd=0 wb_data=0xFFFF, then issue ra=0 → out_a=0x0000.
- Reset asserted while out_valid=1 and pending[6]=1 → next cycle out_valid=0, pending all 0, a read of r6 returns 0 with no stall.
